// File: rtl/register_right_8.sv
// -----------------------------------------------------------------------------
// register_right_8
//
// Serial-in, parallel-out / serial-out right-shift register with a saturating
// shift counter. Bits enter at the MSB and leave at the LSB, so an LSB-first
// serial word appears in dout_pa exactly as transmitted after WIDTH enabled
// shifts.
//
// Parameters:
//   WIDTH   - register length in bits (>= 2), default 8
//
// Ports:
//   clk     - rising-edge clock
//   rst     - synchronous, active-high reset (overrides en)
//   en      - shift enable
//   din     - serial data in, enters at sr[WIDTH-1]
//   dout_pa - parallel view of the shift register
//   dout_se - serial out, the register LSB
//   full    - high once WIDTH enabled shifts have occurred since reset (sticky)
// -----------------------------------------------------------------------------
module register_right_8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             din,
    output logic [WIDTH-1:0] dout_pa,
    output logic             dout_se,
    output logic             full
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

    logic [WIDTH-1:0] r_sr;
    logic [CNT_W-1:0] r_cnt;
    logic             w_cnt_sat;

    assign w_cnt_sat = (r_cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else if (en) begin
            r_sr <= {din, r_sr[WIDTH-1:1]};
            // Counter stops at WIDTH so full stays asserted until reset.
            if (!w_cnt_sat) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Outputs depend on state only; no combinational path from inputs.
    assign dout_pa = r_sr;
    assign dout_se = r_sr[0];
    assign full    = w_cnt_sat;

endmodule

// File: tb/tb_register_right_8.sv
// -----------------------------------------------------------------------------
// tb_register_right_8
//
// Directed self-checking bench for register_right_8 (WIDTH = 8). Expected
// values are hand-computed constants and tables.
// -----------------------------------------------------------------------------
module tb_register_right_8;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             en;
    logic             din;
    logic [WIDTH-1:0] dout_pa;
    logic             dout_se;
    logic             full;

    int checks = 0;
    int errors = 0;

    register_right_8 #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .din     (din),
        .dout_pa (dout_pa),
        .dout_se (dout_se),
        .full    (full)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Drive inputs on the falling edge, let one rising edge pass, then sample
    // 1 time unit after it.
    task automatic step(input logic r, input logic e, input logic d);
        @(negedge clk);
        rst = r;
        en  = e;
        din = d;
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    logic [7:0] load_bits;
    logic [7:0] load_exp [8];
    logic [7:0] ones_exp;

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        din = 1'b1;

        // Reset for 2 cycles with en=1, din=1.
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1, 1'b1);
            check($sformatf("rst_pa_%0d", i), 32'(dout_pa), 32'h00);
            check($sformatf("rst_se_%0d", i), 32'(dout_se), 32'h0);
            check($sformatf("rst_full_%0d", i), 32'(full), 32'h0);
        end

        // Load 0xE2 LSB first.
        load_bits = 8'hE2;
        load_exp  = '{8'h00, 8'h80, 8'h40, 8'h20, 8'h10, 8'h88, 8'hC4, 8'hE2};
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, load_bits[i]);
            check($sformatf("load_pa_%0d", i), 32'(dout_pa), 32'(load_exp[i]));
            check($sformatf("load_full_%0d", i), 32'(full), (i == 7) ? 32'h1 : 32'h0);
        end
        check("load_se", 32'(dout_se), 32'h0);

        // Hold with en=0 and random / unknown din.
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, (i == 2) ? 1'bx : 1'($urandom_range(0, 1)));
            check($sformatf("hold_pa_%0d", i), 32'(dout_pa), 32'hE2);
            check($sformatf("hold_full_%0d", i), 32'(full), 32'h1);
        end

        // Serial drain: dout_se observed before each shift gives 0,1,0,0,0,1,1,1.
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain_se_%0d", i), 32'(dout_se), 32'(load_bits[i]));
            step(1'b0, 1'b1, 1'b0);
        end
        check("drain_pa", 32'(dout_pa), 32'h00);
        check("drain_full", 32'(full), 32'h1);

        // Fill with ones from reset; full on the 8th enabled edge only.
        step(1'b1, 1'b0, 1'b0);
        check("fill_rst_full", 32'(full), 32'h0);
        ones_exp = 8'h00;
        for (int i = 0; i < 8; i++) begin
            ones_exp = {1'b1, ones_exp[7:1]};
            step(1'b0, 1'b1, 1'b1);
            check($sformatf("ones_pa_%0d", i), 32'(dout_pa), 32'(ones_exp));
            check($sformatf("ones_full_%0d", i), 32'(full), (i == 7) ? 32'h1 : 32'h0);
        end
        check("ones_final", 32'(dout_pa), 32'hFF);
        check("ones_se", 32'(dout_se), 32'h1);

        // Extra shifts keep full sticky.
        step(1'b0, 1'b1, 1'b0);
        check("sticky_pa", 32'(dout_pa), 32'h7F);
        check("sticky_full", 32'(full), 32'h1);

        // Reset mid-load.
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b1);
        end
        check("mid_pa", 32'(dout_pa), 32'hE0);
        step(1'b1, 1'b1, 1'b1);
        check("mid_rst_pa", 32'(dout_pa), 32'h00);
        check("mid_rst_full", 32'(full), 32'h0);
        // Counting restarts: 7 shifts not full, with an en gap in between.
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b1, 1'b1);
            if (i == 3) step(1'b0, 1'b0, 1'b0);
        end
        check("restart7_pa", 32'(dout_pa), 32'hFE);
        check("restart7_full", 32'(full), 32'h0);
        step(1'b0, 1'b1, 1'b0);
        check("restart8_pa", 32'(dout_pa), 32'h7F);
        check("restart8_full", 32'(full), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound so the bench cannot hang.
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
